// File: rtl/juggler_pkg.sv
// Types and screen widths shared across the juggler video pipeline.
package juggler_pkg;
  localparam int H_BITS = 11;
  localparam int V_BITS = 10;

  typedef enum logic [1:0] {J_IDLE, J_ARMED, J_SHOW} judge_state_t;
endpackage

// File: rtl/box_outline_hit.sv
// Combinational test of whether a pixel lies on a square outline centred on a point.
module box_outline_hit
  import juggler_pkg::*;
#(
  parameter int BOX_HALF = 24,
  parameter int BORDER   = 3
) (
  input  logic [H_BITS-1:0] hcount,
  input  logic [V_BITS-1:0] vcount,
  input  logic [H_BITS-1:0] centre_x,
  input  logic [V_BITS-1:0] centre_y,
  output logic              on_outline
);

  localparam logic signed [12:0] OUTER = 13'(BOX_HALF);
  localparam logic signed [12:0] INNER = 13'(BOX_HALF - BORDER);

  logic signed [12:0] h, v, cx, cy;
  logic inside_outer, inside_inner;

  // Signed bounds keep a box near the screen edge from wrapping to the far side.
  assign h  = $signed({2'b00, hcount});
  assign v  = $signed({3'b000, vcount});
  assign cx = $signed({2'b00, centre_x});
  assign cy = $signed({3'b000, centre_y});

  assign inside_outer = (h >= cx - OUTER) && (h <= cx + OUTER) &&
                        (v >= cy - OUTER) && (v <= cy + OUTER);
  assign inside_inner = (h >= cx - INNER) && (h <= cx + INNER) &&
                        (v >= cy - INNER) && (v <= cy + INNER);

  assign on_outline = inside_outer && !inside_inner;
endmodule

// File: rtl/judgment_tracker.sv
// Judges each expected catch against the latched target and draws a verdict square.
module judgment_tracker
  import juggler_pkg::*;
#(
  parameter int TOL           = 16,
  parameter int WINDOW_FRAMES = 8,
  parameter int SHOW_FRAMES   = 30,
  parameter int BOX_HALF      = 24,
  parameter int BORDER        = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [H_BITS-1:0] hcount_in,
  input  logic [V_BITS-1:0] vcount_in,
  input  logic              new_frame_in,
  input  logic              judge_req_in,
  input  logic [H_BITS-1:0] target_x_in,
  input  logic [V_BITS-1:0] target_y_in,
  input  logic              centroid_valid_in,
  input  logic [H_BITS-1:0] centroid_x_in,
  input  logic [V_BITS-1:0] centroid_y_in,
  output logic              judgment_out,
  output logic              judgment_correct_out,
  output logic              busy_out
);

  localparam int MAX_FRAMES = (WINDOW_FRAMES > SHOW_FRAMES) ? WINDOW_FRAMES : SHOW_FRAMES;
  localparam int CW         = $clog2(MAX_FRAMES + 1);

  judge_state_t      state, state_next;
  logic [CW-1:0]     frames, frames_next, frames_inc;
  logic [H_BITS-1:0] target_x, target_x_next;
  logic [V_BITS-1:0] target_y, target_y_next;
  logic              correct, correct_next;
  logic              judgment;
  logic              on_outline;
  logic signed [11:0] dx, dy;
  logic [11:0]       abs_dx, abs_dy;
  logic              in_tol;

  // Differences are taken at 12 bits signed so far-apart points never alias near zero.
  assign dx     = $signed({1'b0, centroid_x_in}) - $signed({1'b0, target_x});
  assign dy     = $signed({2'b00, centroid_y_in}) - $signed({2'b00, target_y});
  assign abs_dx = dx[11] ? 12'(-dx) : 12'(dx);
  assign abs_dy = dy[11] ? 12'(-dy) : 12'(dy);
  assign in_tol = (abs_dx <= 12'(TOL)) && (abs_dy <= 12'(TOL));

  assign frames_inc = frames + 1'b1;

  box_outline_hit #(
    .BOX_HALF(BOX_HALF),
    .BORDER  (BORDER)
  ) u_box (
    .hcount    (hcount_in),
    .vcount    (vcount_in),
    .centre_x  (target_x),
    .centre_y  (target_y),
    .on_outline(on_outline)
  );

  always_comb begin
    state_next    = state;
    frames_next   = frames;
    target_x_next = target_x;
    target_y_next = target_y;
    correct_next  = correct;
    // A new request preempts whatever else happens in the same cycle.
    if (judge_req_in) begin
      state_next    = J_ARMED;
      frames_next   = '0;
      target_x_next = target_x_in;
      target_y_next = target_y_in;
    end else begin
      unique case (state)
        J_ARMED: begin
          if (centroid_valid_in && in_tol) begin
            state_next   = J_SHOW;
            frames_next  = '0;
            correct_next = 1'b1;
          end else if (new_frame_in) begin
            if (frames_inc == CW'(WINDOW_FRAMES)) begin
              state_next   = J_SHOW;
              frames_next  = '0;
              correct_next = 1'b0;
            end else begin
              frames_next = frames_inc;
            end
          end
        end
        J_SHOW: begin
          if (new_frame_in) begin
            if (frames_inc == CW'(SHOW_FRAMES)) begin
              state_next  = J_IDLE;
              frames_next = '0;
            end else begin
              frames_next = frames_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The indicator pixel follows the upcoming state so an abort or expiry blanks it at once.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= J_IDLE;
      frames   <= '0;
      target_x <= '0;
      target_y <= '0;
      correct  <= 1'b0;
      judgment <= 1'b0;
    end else begin
      state    <= state_next;
      frames   <= frames_next;
      target_x <= target_x_next;
      target_y <= target_y_next;
      correct  <= correct_next;
      judgment <= (state_next == J_SHOW) && on_outline;
    end
  end

  assign judgment_out         = judgment;
  assign judgment_correct_out = correct;
  assign busy_out             = (state != J_IDLE);
endmodule
